io_hexdisp: RTL

Display back-end of the CPU's I/O path. It takes each 32-bit word the CPU writes to its display output register and renders it on the board's eight seven-segment digits HEX7..HEX0. Hex mode shows the word as 8 hexadecimal digits. Decimal mode runs an iterative 32-cycle binary-to-BCD (double-dabble) conversion and shows up to 8 decimal digits. It sits between the CPU's output CSR write port and the top-level HEX pins.

---
 rtl/io_hexdisp.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/io_hexdisp.sv
// Seven-segment display back-end: renders CPU display-register writes as 8 hex digits
// or, via a 32-step double-dabble conversion, as up to 8 blanked decimal digits.
module io_hexdisp #(
    parameter int CONV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        dec_mode,
    output logic        busy,
    output logic        overflow,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7
);
    // state | meaning
    // IDLE  | waiting for a write
    // CONV  | decimal conversion in progress
    // DONE  | result ready to load into the display
    // PEND  | one queued write is waiting to start
    typedef enum logic [1:0] {IDLE, CONV, DONE, PEND} state_t;

    localparam int SW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    state_t      state;
    logic [31:0] data_q;
    logic [39:0] bcd_q;
    logic [SW-1:0] step_q;
    logic        mode_q;
    logic [31:0] pend_data;
    logic        pend_mode;
    logic        pend_valid;
    logic [6:0]  disp_q [8];

    logic [39:0] bcd_adj;
    logic [6:0]  disp_next [8];
    logic [31:0] start_data;
    logic        start_mode;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Scan from the top digit down so blanking stops at the first nonzero digit.
    always_comb begin
        logic       seen;
        logic [3:0] dig;
        seen = 1'b0;
        dig  = 4'd0;
        for (int i = 0; i < 8; i++) disp_next[i] = 7'h7F;
        for (int i = 7; i >= 0; i--) begin
            dig  = mode_q ? bcd_q[4*i +: 4] : data_q[4*i +: 4];
            seen = seen | (dig != 4'd0);
            if (mode_q && !seen && i != 0)
                disp_next[i] = 7'h7F;
            else
                disp_next[i] = seg7(dig);
        end
    end

    assign start_data = (state == PEND) ? pend_data : wr_data;
    assign start_mode = (state == PEND) ? pend_mode : dec_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_q     <= '0;
            bcd_q      <= '0;
            step_q     <= '0;
            mode_q     <= 1'b0;
            pend_data  <= '0;
            pend_mode  <= 1'b0;
            pend_valid <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            for (int i = 0; i < 8; i++) disp_q[i] <= 7'h7F;
        end else begin
            case (state)
                IDLE, PEND: begin
                    if (state == PEND || wr_en) begin
                        data_q     <= start_data;
                        mode_q     <= start_mode;
                        bcd_q      <= '0;
                        step_q     <= '0;
                        busy       <= 1'b1;
                        pend_valid <= 1'b0;
                        state      <= start_mode ? CONV : DONE;
                    end
                end
                CONV: begin
                    {bcd_q, data_q} <= {bcd_adj, data_q} << 1;
                    step_q          <= step_q + SW'(1);
                    if (step_q == SW'(CONV_CYCLES - 1))
                        state <= DONE;
                end
                DONE: begin
                    for (int i = 0; i < 8; i++) disp_q[i] <= disp_next[i];
                    overflow <= mode_q && (bcd_q[39:32] != 8'd0);
                    if (pend_valid || wr_en) begin
                        state <= PEND;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // Writes arriving while busy land in the one-entry buffer; last write wins.
            if (wr_en && state != IDLE) begin
                pend_data  <= wr_data;
                pend_mode  <= dec_mode;
                pend_valid <= 1'b1;
            end
        end
    end

    assign HEX0 = disp_q[0];
    assign HEX1 = disp_q[1];
    assign HEX2 = disp_q[2];
    assign HEX3 = disp_q[3];
    assign HEX4 = disp_q[4];
    assign HEX5 = disp_q[5];
    assign HEX6 = disp_q[6];
    assign HEX7 = disp_q[7];
endmodule
